// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-mode codes and the default bit divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 115200 baud from a 33 MHz clock; shared with the matching transmitter.
  localparam int UART_CLK_DIV = 286;

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Received-word port: data plus error flags held behind a valid/ready handshake, and an overrun pulse.
interface uart_rx_ovs_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data, data_valid, frame_err, parity_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, frame_err, parity_err, overrun,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_vote.sv
// Bit-window timer and majority voter: counts CLK_DIV cycles while run_i is high and sums rx_s_i,
// pulsing bit_done with the voted bit_val on the last window cycle.
module uart_rx_vote #(
  parameter int CLK_DIV = 286
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic rx_s_i,
  output logic bit_done,
  output logic bit_val
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW:0]   ones_now;
  logic [CW+1:0] ones_x2;

  always_comb begin
    ones_now = {1'b0, ones_q} + (CW + 1)'(rx_s_i);
    ones_x2  = {ones_now, 1'b0};
    bit_done = run_i && (win_q == CW'(CLK_DIV - 1));
    bit_val  = (ones_x2 > (CW + 2)'(CLK_DIV));
    win_d    = win_q;
    ones_d   = ones_q;
    if (!run_i || bit_done) begin
      win_d  = '0;
      ones_d = '0;
    end else begin
      win_d  = win_q + 1'b1;
      ones_d = ones_now[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '0;
      ones_q <= '0;
    end else begin
      win_q  <= win_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Parametrised UART receiver with whole-window bit voting, framing/parity/overrun flags and a held output word.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = UART_CLK_DIV,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = PAR_NONE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_ovs_if.master dout
);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PAR_ACTIVE = PAR_EN && (PARITY_MODE != PAR_NONE);
  localparam int IW         = $clog2(DATA_BITS);

  logic                 rx_meta_q, rx_s_q;
  uart_state_e          state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 run, accept, frame_done, bit_done, bit_val;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 pe_q, pe_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The start-detect cycle in IDLE is already window cycle 0, so the voter runs in it.
  assign run    = (state_q != UART_IDLE) || !rx_s_q;
  assign accept = valid_q && dout.data_ready;

  uart_rx_vote #(.CLK_DIV(CLK_DIV)) u_vote (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run),
    .rx_s_i   (rx_s_q),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fe_d       = fe_q;
    ovr_d      = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
    pe_d       = pe_q;
`endif
    case (state_q)
      UART_IDLE: begin
        if (!rx_s_q) begin
          state_d = UART_START;
          idx_d   = '0;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      UART_START: begin
        if (bit_done) state_d = bit_val ? UART_IDLE : UART_DATA;
      end
      UART_DATA: begin
        if (bit_done) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = PAR_ACTIVE ? UART_PARITY : UART_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      UART_PARITY: begin
        if (bit_done) begin
          perr_d  = bit_val ^ (^shift_q) ^ (PARITY_MODE == PAR_ODD);
          state_d = UART_STOP;
        end
      end
`endif
      UART_STOP: begin
        if (bit_done) begin
          if (!bit_val) ferr_d = 1'b1;
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_d      = '0;
            state_d    = UART_IDLE;
            frame_done = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase

    // A completed frame may only replace a word that is absent or leaving this cycle.
    if (frame_done) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        fe_d    = ferr_d;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        pe_d    = perr_d;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      perr_q <= perr_d;
      pe_q   <= pe_d;
    end
  end
  assign dout.parity_err = pe_q;
`else
  assign dout.parity_err = 1'b0;
`endif

  assign dout.data       = data_q;
  assign dout.data_valid = valid_q;
  assign dout.frame_err  = fe_q;
  assign dout.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: directed frames plus randomized traffic against a transaction-level model.
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int CD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7;
  localparam int PM = PAR_EVEN;
  localparam bit PAR_ON = 1'b1;
`else
  localparam int DB = 8;
  localparam int PM = PAR_NONE;
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int SB    = 1;
  localparam int NBITS = 1 + DB + (PAR_ON ? 1 : 0) + SB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  always #5 clk = ~clk;

  uart_rx_ovs_if #(.DATA_BITS(DB)) u_if ();

  uart_rx_ovs #(
    .CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_MODE(PM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .dout(u_if.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DB-1:0] d;
    bit            fe;
    bit            pe;
    int            done;
  } exp_t;

  exp_t          pend[$];
  logic [DB-1:0] m_data, cap_data;
  bit            m_valid, m_fe, m_pe, m_ovr, cap_fe, cap_pe, prev_valid, mon_en;
  int            rdy_mode = 2;
  int            rdy_at   = 0;
  int            ovr_seen = 0;
  int            rise_cnt = 0;
  int            rise_cyc = 0;

  function automatic logic [DB-1:0] w(input logic [7:0] x);
    return x[DB-1:0];
  endfunction

  // Output-register model: words arrive at their computed completion edge and leave on accept.
  initial begin
    exp_t e;
    bit   acc, rdy;
    m_data = '0; m_valid = 0; m_fe = 0; m_pe = 0; m_ovr = 0; prev_valid = 0;
    u_if.data_ready = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #1;
      check_eq("valid", 32'(u_if.data_valid), 32'(m_valid));
      check_eq("overrun", 32'(u_if.overrun), 32'(m_ovr));
      if (m_valid) begin
        check_eq("data", 32'(u_if.data), 32'(m_data));
        check_eq("frame_err", 32'(u_if.frame_err), 32'(m_fe));
        check_eq("parity_err", 32'(u_if.parity_err), 32'(m_pe));
      end
      if (u_if.overrun) ovr_seen++;
      if (u_if.data_valid) begin
        cap_data = u_if.data;
        cap_fe   = u_if.frame_err;
        cap_pe   = u_if.parity_err;
        if (!prev_valid) begin
          rise_cnt++;
          rise_cyc = cyc;
        end
      end
      prev_valid = u_if.data_valid;
      case (rdy_mode)
        0:       rdy = ($urandom_range(0, 9) < 4);
        1:       rdy = 1'b0;
        2:       rdy = 1'b1;
        default: rdy = (cyc + 1 == rdy_at);
      endcase
      u_if.data_ready = rdy;
      m_ovr = 0;
      if (rst) begin
        m_data = '0; m_valid = 0; m_fe = 0; m_pe = 0;
        pend.delete();
      end else begin
        acc = m_valid && rdy;
        if (pend.size() > 0 && pend[0].done == cyc + 1) begin
          e = pend.pop_front();
          if (!m_valid || acc) begin
            m_data = e.d; m_fe = e.fe; m_pe = e.pe; m_valid = 1;
          end else begin
            m_ovr = 1;
          end
        end else if (acc) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one whole frame, each bit held for CD cycles.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_bad, input bit par_flip,
                            input int gbit, input int glen, output int fall);
    logic [NBITS-1:0] fb;
    exp_t e;
    fb[0] = 1'b0;
    for (int i = 0; i < DB; i++) fb[1+i] = d[i];
    if (PAR_ON) fb[1+DB] = (^d) ^ (PM == PAR_ODD) ^ par_flip;
    for (int s = 0; s < SB; s++) fb[NBITS-1-s] = !stop_bad;
    fall   = cyc;
    e.d    = d;
    e.fe   = stop_bad;
    e.pe   = PAR_ON && par_flip;
    e.done = cyc + 2 + NBITS * CD;
    pend.push_back(e);
    for (int b = 0; b < NBITS; b++) begin
      for (int i = 0; i < CD; i++) begin
        rx = fb[b] ^ ((b == gbit) && (i >= 6) && (i < 6 + glen));
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    int            f, o0, r0;
    logic [DB-1:0] v;
    logic [7:0]    pv;
    bit            sbad, pf;
    int            gb;

    repeat (3) @(negedge clk);
    mon_en = 1;
    @(negedge clk);
    #2;
    check_eq("rst_valid", 32'(u_if.data_valid), 0);
    check_eq("rst_data", 32'(u_if.data), 0);
    check_eq("rst_overrun", 32'(u_if.overrun), 0);
    rst = 1'b0;
    idle(5);

    send_frame(w(8'hA5), 0, 0, -1, 0, f);
    idle(4);
    check_eq("basic_latency", 32'(rise_cyc - (f + 2)), 32'(NBITS * CD));
    check_eq("basic_data", 32'(cap_data), 32'(w(8'hA5)));
    check_eq("basic_fe", 32'(cap_fe), 0);

    // A 5-cycle low pulse must vote high; the next start 16 cycles later proves IDLE again.
    r0 = rise_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(11);
    send_frame(w(8'h5A), 0, 0, 3, 3, f);
    idle(4);
    check_eq("glitch_rises", 32'(rise_cnt - r0), 1);
    check_eq("glitch_data", 32'(cap_data), 32'(w(8'h5A)));
    check_eq("glitch_latency", 32'(rise_cyc - (f + 2)), 32'(NBITS * CD));

    send_frame(w(8'h3C), 1, 0, -1, 0, f);
    idle(4);
    check_eq("frame_data", 32'(cap_data), 32'(w(8'h3C)));
    check_eq("frame_fe", 32'(cap_fe), 1);
    idle(20);

    rdy_mode = 1;
    o0 = ovr_seen;
    send_frame(w(8'h11), 0, 0, -1, 0, f);
    send_frame(w(8'h22), 0, 0, -1, 0, f);
    idle(4);
    check_eq("ovr_data", 32'(u_if.data), 32'(w(8'h11)));
    check_eq("ovr_valid", 32'(u_if.data_valid), 1);
    check_eq("ovr_pulses", 32'(ovr_seen - o0), 1);

    o0 = ovr_seen;
    r0 = rise_cnt;
    rdy_at = cyc + 2 + NBITS * CD;
    rdy_mode = 3;
    send_frame(w(8'h33), 0, 0, -1, 0, f);
    idle(4);
    check_eq("same_cycle_data", 32'(u_if.data), 32'(w(8'h33)));
    check_eq("same_cycle_valid", 32'(u_if.data_valid), 1);
    check_eq("same_cycle_no_drop", 32'(rise_cnt - r0), 0);
    check_eq("same_cycle_no_ovr", 32'(ovr_seen - o0), 0);

    // Abort a frame halfway through data bit 3 while a word is still held.
    pv = 8'h44;
    for (int k = 0; k < 4 * CD + CD / 2; k++) begin
      if (k < CD) rx = 1'b0;
      else        rx = pv[k/CD-1];
      @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    #2;
    check_eq("midrst_valid", 32'(u_if.data_valid), 0);
    check_eq("midrst_data", 32'(u_if.data), 0);
    check_eq("midrst_fe", 32'(u_if.frame_err), 0);
    check_eq("midrst_pe", 32'(u_if.parity_err), 0);
    rst = 1'b0;
    idle(10);
    rdy_mode = 2;
    send_frame(w(8'h7E), 0, 0, -1, 0, f);
    idle(4);
    check_eq("post_rst_data", 32'(u_if.data), 32'(w(8'h7E)));
    check_eq("post_rst_fe", 32'(cap_fe), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(w(8'h55), 0, 0, -1, 0, f);
    idle(4);
    check_eq("par_ok", 32'(cap_pe), 0);
    send_frame(w(8'h55), 0, 1, -1, 0, f);
    idle(4);
    check_eq("par_bad", 32'(cap_pe), 1);
`endif

    rdy_mode = 0;
    for (int n = 0; n < 40; n++) begin
      v    = DB'($urandom);
      sbad = ($urandom_range(0, 7) == 0);
      pf   = PAR_ON && ($urandom_range(0, 3) == 0);
      gb   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, NBITS - 1));
      send_frame(v, sbad, pf, gb, int'($urandom_range(1, 3)), f);
      if ($urandom_range(0, 3) != 0) idle(int'($urandom_range(1, 30)));
    end
    rdy_mode = 2;
    idle(10);
    check_eq("drain", 32'(pend.size()), 0);
    check_eq("drain_valid", 32'(u_if.data_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised UART receiver: the successor to the fixed 115200 8-N-1 receiver in the LPC-UART design. It adds configurable divisor, data width, stop bits and optional parity. It votes each bit over its whole bit window, flags framing, parity and overrun errors, and holds each received word behind a valid/ready handshake. It sits between the board RX pin and the LPC register file or FIFO.

## Interface
- `CLK_DIV`, default 286: clock cycles per bit (286 gives 115200 baud at 33 MHz); legal range ≥ 4.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `PARITY_MODE`, default 0: 0 = none, 1 = even, 2 = odd; only effective with `UART_RX_PARITY_EN`.

- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rx` input 1: asynchronous serial line; idles high.
- `data` output DATA_BITS: received word, LSB first on the line.
- `data_valid` output 1: `data` and error flags are valid; held until accepted.
- `data_ready` input 1: consumer accepts the word when `data_valid && data_ready`.
- `frame_err` output 1: a stop bit voted 0; qualified by `data_valid`.
- `parity_err` output 1: parity mismatch; qualified by `data_valid`; constant 0 without the macro.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- FSM states: IDLE → START → DATA → PARITY (only if enabled and `PARITY_MODE` ≠ 0) → STOP → IDLE.
- IDLE: when `rx_s` = 0, go to START and clear the window counter and ones counter. The detect cycle is window cycle 0.
- Each bit window lasts CLK_DIV cycles. On every window cycle, `ones += rx_s`.
- On the last window cycle, vote: `bit = (2*ones > CLK_DIV)`. Then clear both counters.
- Counter widths are `$clog2(CLK_DIV+1)`. No wrap is possible.
- START: if the vote is 1 (false start), return to IDLE silently. Otherwise go to DATA.
- DATA: shift the bit in, LSB first. A bit index counts from 0 to DATA_BITS-1, then the FSM advances.
- PARITY: compare the received bit against the XOR of the data bits (even) or its inverse (odd). Latch the mismatch.
- STOP: any stop window that votes 0 sets the frame error. After the last stop window the frame is complete and the FSM returns to IDLE.
- A framing error does not block delivery; the word is delivered with `frame_err` = 1.
- Frame completion:
  - If the output register is empty, or is being accepted this same cycle, load `data`, `frame_err` and `parity_err`, and set `data_valid`.
  - Otherwise the old word is kept, the new word is dropped, and `overrun` pulses.
- Accept with no new frame: clear `data_valid`. `data` keeps its last value.
- Reset at any point, including mid-frame or with `data_valid` high:
  - FSM goes to IDLE and all counters clear.
  - `data` = 0, `data_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0.

## Timing
- Start detection occurs 2 cycles after the falling edge on the `rx` pin (synchronizer latency).
- `data_valid` rises exactly N·CLK_DIV cycles after the detect cycle.
  - N = 1 + DATA_BITS + P + STOP_BITS, where P = 1 if parity is active, else 0.
  - Registered output, no combinational path from `rx`.
- The FSM is in IDLE on the cycle after the last stop vote. This allows back-to-back frames with zero idle time.
- `data_valid` drops on the cycle after acceptance, unless a frame completes in that same accepting cycle; then it stays high.
- `overrun` is high for exactly 1 cycle per dropped frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, parity checker and `parity_err` register are compiled in.
  - `PARITY_MODE` selects none, even or odd.
- Not defined:
  - No PARITY state; `PARITY_MODE` is ignored.
  - `parity_err` is tied to 0.
  - Frames are always 1 + DATA_BITS + STOP_BITS bits long.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`);
  - parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - the default `CLK_DIV` of 286, for reuse by the matching transmitter.
- One sub-module, `uart_rx_vote`, contains the window counter, ones counter and majority vote. Its outputs are `bit_done` (pulse) and `bit_val`.

## Test plan
- All directed tests use CLK_DIV=16 unless stated.
- Basic frame: send 8-N-1 0xA5 → `data_valid` rises 160 cycles after detect, `data`=0xA5, both error flags 0.
- Glitch rejection: a 5-cycle low pulse on idle `rx` → false start, no `data_valid`, FSM back in IDLE after 16 cycles. Also, a 3-cycle glitch inside a data bit → the bit value is unchanged.
- Framing error: 0x3C sent with the stop bit held low → `data`=0x3C, `frame_err`=1.
- Parity (macro on, PARITY_MODE=1, DATA_BITS=7):
  - 0x55 with correct even parity bit 0 → `parity_err`=0.
  - Parity bit flipped → `parity_err`=1.
- Handshake and overrun, `data_ready` held low:
  - Send 0x11 then 0x22 back-to-back → `data` stays 0x11 and `overrun` pulses once.
  - Raise `data_ready` in the cycle 0x33 completes → 0x33 is loaded, `data_valid` stays high, no overrun.
- Reset mid-frame: assert `rst` during DATA bit 3 → all outputs 0 next cycle; a following frame 0x7E is received correctly.
